// File: rtl/fp_normalize_round_pkg.sv
// Shared types and constants for the binary32 normalize/round stage.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 26;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_normalize_round_if.sv
// Upstream/downstream handshake bundle of the normalize/round stage.
interface fp_normalize_round_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              sign_in;
  logic [EXP_W-1:0]  exp_in;
  logic [MAN_W-1:0]  mantis_in;
  logic              loss_in;
  logic              operator_in;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              overflow;
  logic              inexact;
  logic              busy;

  modport master (
    output in_valid, sign_in, exp_in, mantis_in, loss_in, operator_in, out_ready,
    input  in_ready, out_valid, result, overflow, inexact, busy
  );

  modport slave (
    input  in_valid, sign_in, exp_in, mantis_in, loss_in, operator_in, out_ready,
    output in_ready, out_valid, result, overflow, inexact, busy
  );

endinterface

// File: rtl/fp_normalize_round_rne.sv
// Round-to-nearest-even of a normalized (or denormal) 24-bit significand plus guard.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MAN_W-2:0]  mant,
  input  logic              sticky,
  input  logic signed [9:0] exp,
  output logic [FRAC_W-1:0] frac,
  output logic [EXP_W-1:0]  exp_adj,
  output logic              overflow,
  output logic              inexact
);

  logic              guard;
  logic              lsb;
  logic              inc;
  logic [FRAC_W+1:0] sum;
  logic signed [9:0] exp_full;

  always_comb begin
    guard    = mant[0];
    lsb      = mant[1];
    inc      = guard & (sticky | lsb);
    sum      = {1'b0, mant[FRAC_W+1:1]} + {{(FRAC_W+1){1'b0}}, inc};
    exp_full = exp;
    // Carry past the hidden bit renormalizes; a denormal that gains its hidden bit becomes exp 1.
    if (sum[FRAC_W+1]) begin
      exp_full = exp + 10'sd1;
    end else if (exp == 10'sd0 && sum[FRAC_W]) begin
      exp_full = 10'sd1;
    end
    overflow = (exp_full >= 10'sd255);
    frac     = (sum[FRAC_W+1] || overflow) ? '0 : sum[FRAC_W-1:0];
    exp_adj  = overflow ? EXP_MAX : exp_full[EXP_W-1:0];
    inexact  = guard | sticky;
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Iterative normalize + RNE round stage producing binary32; one operation in flight.
// FP_FLUSH_DENORM_EN: when defined, results with a zero exponent field flush to signed zero.
module fp_normalize_round
  import fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fp_normalize_round_if.slave  bus
);

  state_t            state_reg, state_next;
  logic              sign_reg, sign_next;
  logic              op_reg, op_next;
  logic signed [9:0] exp_reg, exp_next;
  logic [MAN_W-1:0]  mant_reg, mant_next;
  logic              sticky_reg, sticky_next;
  logic              special_reg, special_next;
  fp32_t             result_reg, result_next;
  logic              overflow_reg, overflow_next;
  logic              inexact_reg, inexact_next;

  logic [FRAC_W-1:0] rnd_frac;
  logic [EXP_W-1:0]  rnd_exp;
  logic              rnd_overflow;
  logic              rnd_inexact;

  fp_round_rne u_round (
    .mant     (mant_reg[MAN_W-2:0]),
    .sticky   (sticky_reg),
    .exp      (exp_reg),
    .frac     (rnd_frac),
    .exp_adj  (rnd_exp),
    .overflow (rnd_overflow),
    .inexact  (rnd_inexact)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sign_reg     <= 1'b0;
      op_reg       <= 1'b0;
      exp_reg      <= '0;
      mant_reg     <= '0;
      sticky_reg   <= 1'b0;
      special_reg  <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      inexact_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sign_reg     <= sign_next;
      op_reg       <= op_next;
      exp_reg      <= exp_next;
      mant_reg     <= mant_next;
      sticky_reg   <= sticky_next;
      special_reg  <= special_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      inexact_reg  <= inexact_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sign_next     = sign_reg;
    op_next       = op_reg;
    exp_next      = exp_reg;
    mant_next     = mant_reg;
    sticky_next   = sticky_reg;
    special_next  = special_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    inexact_next  = inexact_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next   = NORM;
          sign_next    = bus.sign_in;
          op_next      = bus.operator_in;
          exp_next     = $signed({2'b00, bus.exp_in});
          mant_next    = bus.mantis_in;
          sticky_next  = bus.loss_in;
          special_next = 1'b0;
        end
      end
      NORM: begin
        if (exp_reg == 10'sd255) begin
          special_next = 1'b1;
          state_next   = ROUND;
        end else if (mant_reg == '0) begin
          // Exact cancellation of a subtraction yields +0.
          sign_next  = op_reg ? 1'b0 : sign_reg;
          exp_next   = '0;
          state_next = ROUND;
        end else if (mant_reg[MAN_W-1]) begin
          mant_next   = {1'b0, mant_reg[MAN_W-1:1]};
          sticky_next = sticky_reg | mant_reg[0];
          exp_next    = exp_reg + 10'sd1;
          state_next  = ROUND;
        end else if (mant_reg[MAN_W-2]) begin
          state_next = ROUND;
        end else if (exp_reg <= 10'sd1) begin
          exp_next   = '0;
          state_next = ROUND;
        end else begin
          mant_next = {mant_reg[MAN_W-2:0], 1'b0};
          exp_next  = exp_reg - 10'sd1;
        end
      end
      ROUND: begin
        state_next = DONE;
        if (special_reg) begin
          result_next.sign = sign_reg;
          result_next.exp  = EXP_MAX;
          result_next.frac = mant_reg[FRAC_W:1];
          overflow_next    = 1'b0;
          inexact_next     = 1'b0;
        end else begin
          result_next.sign = sign_reg;
          result_next.exp  = rnd_exp;
          result_next.frac = rnd_frac;
          overflow_next    = rnd_overflow;
          inexact_next     = rnd_inexact;
`ifdef FP_FLUSH_DENORM_EN
          if (!rnd_overflow && rnd_exp == '0) begin
            result_next.exp  = '0;
            result_next.frac = '0;
            inexact_next     = rnd_inexact | (mant_reg != '0);
          end
`else
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.result    = result_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.inexact   = inexact_reg;

endmodule
